// File: rtl/line_memory.sv
//------------------------------------------------------------------------------
// Module      : line_memory
// Description : 256-bit line backing memory with a fixed access latency and a
//               one-cycle ack, serving a data cache refill/write-back port.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module line_memory #(
    parameter int LINES   = 512,
    parameter int LATENCY = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic         ack_o,
    output logic [255:0] data_o,
    output logic         busy_o
);

    localparam int IDX_W = $clog2(LINES);
    localparam int CNT_W = $clog2(LATENCY + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] index;
    logic             is_write;
    logic [255:0]     wdata;
    logic             commit;
    logic             unused_addr;

    logic [255:0] memory [LINES];

    // Offset and aliasing address bits are intentionally discarded.
    assign unused_addr = ^{addr_i[31:5+IDX_W], addr_i[4:0]};

    assign commit = (state == BUSY) && (count == CNT_W'(1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable_i) state_next = BUSY;
            BUSY:    if (commit)   state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ack_o  = (state == ACK);
        busy_o = (state != IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count    <= '0;
            index    <= '0;
            is_write <= 1'b0;
            wdata    <= '0;
            data_o   <= '0;
        end else begin
            if (state == IDLE && enable_i) begin
                count    <= CNT_W'(LATENCY - 1);
                index    <= addr_i[5+IDX_W-1:5];
                is_write <= write_i;
                wdata    <= data_i;
            end else if (state == BUSY) begin
                count <= count - CNT_W'(1);
            end
            if (commit && !is_write) begin
                data_o <= memory[index];
            end
        end
    end

    // Array has no reset so its contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (commit && is_write) begin
            memory[index] <= wdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_line_memory.sv
//------------------------------------------------------------------------------
// Module      : tb_line_memory
// Description : Self-checking bench for line_memory against a line-array model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_line_memory;

    localparam int L = 10;
    localparam int N = 512;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en  = 1'b0;
    logic         wr  = 1'b0;
    logic [31:0]  addr = '0;
    logic [255:0] din  = '0;
    logic         ack;
    logic         busy;
    logic [255:0] dout;

    line_memory #(.LINES(N), .LATENCY(L)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .enable_i (en),
        .write_i  (wr),
        .addr_i   (addr),
        .data_i   (din),
        .ack_o    (ack),
        .data_o   (dout),
        .busy_o   (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [255:0] model [N];
    logic [255:0] last_rd;

    typedef struct {
        logic         w;
        logic [31:0]  a;
        logic [255:0] d;
        logic [255:0] exp;
    } vec_t;
    vec_t vecs [6];

    function automatic logic [255:0] pre(input int i);
        return {8{32'h1000_0000 + 32'(i)}};
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One transaction; enable is dropped (and inputs scrambled) at drop_at.
    task automatic txn(input logic w, input logic [31:0] a, input logic [255:0] d,
                       input logic [255:0] exp, input int drop_at, input string name);
        @(negedge clk);
        en = 1'b1; wr = w; addr = a; din = d;
        for (int k = 1; k <= L + 2; k++) begin
            @(negedge clk);
            check($sformatf("%s busy c%0d", name, k), 256'(busy), 256'(k <= L));
            check($sformatf("%s ack c%0d", name, k), 256'(ack), 256'(k == L));
            if (k >= L) check($sformatf("%s data c%0d", name, k), dout, exp);
            if (k == drop_at) begin
                en = 1'b0; addr = a + 32'h20; din = ~d; wr = ~w;
            end
        end
        if (w) model[a[13:5]] = d;
        else   last_rd = exp;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic        w;
        logic [31:0] a;
        logic [255:0] d;
        logic [255:0] p;

        for (int i = 0; i < N; i++) begin
            model[i] = pre(i);
            dut.memory[i] = pre(i);
        end
        last_rd = '0;

        vecs[0] = '{1'b1, 32'h0000_0040, {8{32'hDEAD_BEEF}}, 256'h0};
        vecs[1] = '{1'b0, 32'h0000_0040, 256'h0, {8{32'hDEAD_BEEF}}};
        vecs[2] = '{1'b1, 32'h0000_0060, {8{32'h6060_1234}}, {8{32'hDEAD_BEEF}}};
        vecs[3] = '{1'b0, 32'h0000_007F, 256'h0, {8{32'h6060_1234}}};
        vecs[4] = '{1'b0, 32'h0000_4060, 256'h0, {8{32'h6060_1234}}};
        vecs[5] = '{1'b1, 32'h0000_0100, {8{32'h0BAD_F00D}}, {8{32'h6060_1234}}};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset busy", 256'(busy), 256'(0));
        check("reset ack", 256'(ack), 256'(0));
        check("reset data", dout, 256'h0);

        for (int i = 0; i < 6; i++)
            txn(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp, L, $sformatf("vec%0d", i));

        // Inputs change and enable drops in cycle 3.
        txn(1'b0, 32'h0000_0080, 256'h0, model[4], 3, "midflight");

        // Enable held high across two requests.
        @(negedge clk);
        en = 1'b1; wr = 1'b0; addr = 32'h0000_0040;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            check($sformatf("b2b busy c%0d", k), 256'(busy), 256'(k != 11 && k <= 21));
            check($sformatf("b2b ack c%0d", k), 256'(ack), 256'(k == 10 || k == 21));
            if (k == 10) check("b2b data1", dout, model[2]);
            if (k == 21) check("b2b data2", dout, model[3]);
            if (k == 5)  addr = 32'h0000_0060;
            if (k == 21) en = 1'b0;
        end
        last_rd = model[3];

        // Reset during a pending write discards it.
        @(negedge clk);
        en = 1'b1; wr = 1'b1; addr = 32'h0000_00C0; din = '1;
        repeat (5) @(negedge clk);
        en = 1'b0;
        rst = 1'b1;
        #1;
        check("rstmid busy", 256'(busy), 256'(0));
        check("rstmid ack", 256'(ack), 256'(0));
        check("rstmid data", dout, 256'h0);
        @(negedge clk);
        rst = 1'b0;
        last_rd = '0;
        txn(1'b0, 32'h0000_00C0, 256'h0, model[6], L, "after_rst");

        // Reset in the ACK cycle of a committed write.
        p = {8{32'hC0FF_EE15}};
        @(negedge clk);
        en = 1'b1; wr = 1'b1; addr = 32'h0000_01E0; din = p;
        repeat (L) @(negedge clk);
        check("rstack ack before", 256'(ack), 256'(1));
        en = 1'b0;
        rst = 1'b1;
        #1;
        check("rstack ack", 256'(ack), 256'(0));
        check("rstack busy", 256'(busy), 256'(0));
        check("rstack data", dout, 256'h0);
        @(negedge clk);
        rst = 1'b0;
        model[15] = p;
        last_rd = '0;
        txn(1'b0, 32'h0000_01E0, 256'h0, model[15], L, "committed");

        for (int t = 0; t < 40; t++) begin
            w = 1'($urandom_range(0, 1));
            a = $urandom;
            a[13:5] = 9'($urandom_range(0, 15));
            d = {$urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom};
            txn(w, a, d, w ? last_rd : model[a[13:5]], L, $sformatf("rnd%0d", t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
